lora_rx_chirp_demod: RTL and testbench

- Receive-side counterpart of the TX chirp frequency incrementer.
- Consumes instantaneous-frequency samples (same signed PRECISION format and ±BW_SR wrap range as TX).
- Per sample: takes the frequency step and detects the single wrap discontinuity within each symbol.
- Converts the wrap position into the LoRa symbol value and emits it over a valid/ready interface to the downstream decoder.

---
 rtl/lora_rx_chirp_demod.sv | 201 ++++++++++++++++++++
 tb/tb_lora_rx_chirp_demod.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lora_rx_chirp_demod.sv
// ---------------------------------------------------------------------------
// lora_rx_chirp_demod
//   Receive-side chirp demodulator. It takes a stream of instantaneous-frequency
//   samples, measures the sample-to-sample frequency step and finds the single
//   wrap discontinuity inside each symbol. The symbol value is N - wrap_index.
//   Results go to the downstream decoder over a valid/ready handshake.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   start              : one-cycle pulse; latches configuration, (re)starts alignment
//   sf, chirpType      : spreading factor (clamped to SF_MIN..SF_MAX), up/down chirp
//   BW_SR              : positive frequency wrap limit
//   phaseInc_val       : nominal per-sample step (latched, not used by detection)
//   freq_in/freq_valid : signed frequency sample and its qualifier
//   sym_out/sym_valid/sym_ready/sym_err : symbol result handshake, error flag
//   overflow           : sticky; a result overwrote an unaccepted one
//   busy               : high while in RUN
// ---------------------------------------------------------------------------
`ifndef CHIRP_TYPE_SIZE
`define CHIRP_TYPE_SIZE 1
`endif
`ifndef TYPE_UPCHIRP
`define TYPE_UPCHIRP 1'b0
`endif
`ifndef TYPE_DOWNCHIRP
`define TYPE_DOWNCHIRP 1'b1
`endif

module lora_rx_chirp_demod #(
    parameter int PRECISION = 16,
    parameter int SF_MAX    = 12,
    parameter int SF_MIN    = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [3:0]                  sf,
    input  logic [`CHIRP_TYPE_SIZE-1:0] chirpType,
    input  logic [PRECISION-1:0]        BW_SR,
    input  logic [PRECISION-1:0]        phaseInc_val,
    input  logic signed [PRECISION-1:0] freq_in,
    input  logic                        freq_valid,
    output logic [SF_MAX-1:0]           sym_out,
    output logic                        sym_valid,
    input  logic                        sym_ready,
    output logic                        sym_err,
    output logic                        overflow,
    output logic                        busy
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [3:0]        SF_MIN_4 = 4'(SF_MIN);
    localparam logic [3:0]        SF_MAX_4 = 4'(SF_MAX);
    localparam logic [SF_MAX-1:0] CNT_ZERO = {SF_MAX{1'b0}};
    localparam logic [SF_MAX-1:0] CNT_ONE  = {{(SF_MAX-1){1'b0}}, 1'b1};

    state_t                        state_r, state_next_s;
    logic [SF_MAX-1:0]             mask_r, counter_r, wrap_idx_r;
    logic [`CHIRP_TYPE_SIZE-1:0]   chirp_r;
    logic [PRECISION-1:0]          bw_r, phase_inc_r;
    logic signed [PRECISION-1:0]   prev_r;
    logic                          first_r, seen_r, err_r;
    logic [SF_MAX-1:0]             sym_out_r;
    logic                          sym_valid_r, sym_err_r, overflow_r, busy_r;

    logic [3:0]                    sf_eff_s;
    logic [SF_MAX-1:0]             mask_s, idx_next_s, sym_calc_s;
    logic signed [PRECISION:0]     diff_s, limit_s;
    logic                          accept_s, last_s, wrap_raw_s, wrap_now_s;
    logic                          seen_next_s, err_next_s, complete_s;
    logic                          unused_cfg_s;

    // The nominal step is kept with the configuration but detection only needs BW_SR.
    assign unused_cfg_s = ^phase_inc_r;

    // Clamp the requested spreading factor and derive the counter mask N-1.
    always_comb begin
        if (sf < SF_MIN_4) begin
            sf_eff_s = SF_MIN_4;
        end else if (sf > SF_MAX_4) begin
            sf_eff_s = SF_MAX_4;
        end else begin
            sf_eff_s = sf;
        end
        mask_s = {SF_MAX{1'b1}} >> (SF_MAX_4 - sf_eff_s);
    end

    // Next-state logic: start moves to RUN, RUN is left only by reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-sample wrap detection and the symbol value it implies.
    always_comb begin
        accept_s = (state_r == ST_RUN) && freq_valid && !start;
        last_s   = (counter_r == mask_r);
        // One extra bit keeps the difference of two full-range samples exact.
        diff_s   = {freq_in[PRECISION-1], freq_in} - {prev_r[PRECISION-1], prev_r};
        limit_s  = {1'b0, bw_r};
        if (chirp_r == `TYPE_UPCHIRP) begin
            wrap_raw_s = (diff_s < -limit_s);
        end else begin
            wrap_raw_s = (diff_s > limit_s);
        end
        // The step into a new symbol (and the first step after start) is never a wrap.
        wrap_now_s  = accept_s && wrap_raw_s && !first_r && (counter_r != CNT_ZERO);
        seen_next_s = seen_r || wrap_now_s;
        err_next_s  = err_r || (wrap_now_s && seen_r);
        if (seen_r) begin
            idx_next_s = wrap_idx_r;
        end else begin
            idx_next_s = counter_r;
        end
        if (seen_next_s) begin
            sym_calc_s = (mask_r - idx_next_s + CNT_ONE) & mask_r;
        end else begin
            sym_calc_s = CNT_ZERO;
        end
        complete_s = accept_s && last_s;
    end

    // State, configuration, datapath and output-handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mask_r      <= CNT_ZERO;
            counter_r   <= CNT_ZERO;
            wrap_idx_r  <= CNT_ZERO;
            chirp_r     <= {`CHIRP_TYPE_SIZE{1'b0}};
            bw_r        <= {PRECISION{1'b0}};
            phase_inc_r <= {PRECISION{1'b0}};
            prev_r      <= {PRECISION{1'b0}};
            first_r     <= 1'b0;
            seen_r      <= 1'b0;
            err_r       <= 1'b0;
            sym_out_r   <= CNT_ZERO;
            sym_valid_r <= 1'b0;
            sym_err_r   <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            if (start) begin
                mask_r      <= mask_s;
                chirp_r     <= chirpType;
                bw_r        <= BW_SR;
                phase_inc_r <= phaseInc_val;
                first_r     <= 1'b1;
                overflow_r  <= 1'b0;
                counter_r   <= CNT_ZERO;
                seen_r      <= 1'b0;
                err_r       <= 1'b0;
                wrap_idx_r  <= CNT_ZERO;
            end else if (accept_s) begin
                prev_r    <= freq_in;
                first_r   <= 1'b0;
                counter_r <= (counter_r + CNT_ONE) & mask_r;
                if (last_s) begin
                    seen_r     <= 1'b0;
                    err_r      <= 1'b0;
                    wrap_idx_r <= CNT_ZERO;
                end else begin
                    seen_r     <= seen_next_s;
                    err_r      <= err_next_s;
                    wrap_idx_r <= idx_next_s;
                end
            end
            // A new result wins over a pending one; losing an unaccepted result is flagged.
            if (complete_s) begin
                sym_out_r   <= sym_calc_s;
                sym_err_r   <= err_next_s;
                sym_valid_r <= 1'b1;
                if (sym_valid_r && !sym_ready) begin
                    overflow_r <= 1'b1;
                end
            end else if (sym_valid_r && sym_ready) begin
                sym_valid_r <= 1'b0;
            end
        end
    end

    assign sym_out   = sym_out_r;
    assign sym_valid = sym_valid_r;
    assign sym_err   = sym_err_r;
    assign overflow  = overflow_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_lora_rx_chirp_demod.sv
// ---------------------------------------------------------------------------
// tb_lora_rx_chirp_demod
//   Directed and randomized checks of the chirp demodulator. Sample tables are
//   synthesized from ideal chirps; expected symbols come from hand-derived
//   constants and from a reference model that scans a whole symbol for wraps.
// ---------------------------------------------------------------------------
`ifndef CHIRP_TYPE_SIZE
`define CHIRP_TYPE_SIZE 1
`endif
`ifndef TYPE_UPCHIRP
`define TYPE_UPCHIRP 1'b0
`endif
`ifndef TYPE_DOWNCHIRP
`define TYPE_DOWNCHIRP 1'b1
`endif

module tb_lora_rx_chirp_demod;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [3:0]                  sf;
    logic [`CHIRP_TYPE_SIZE-1:0] chirp_type;
    logic [15:0]                 bw_sr;
    logic [15:0]                 phase_inc;
    logic signed [15:0]          freq_in;
    logic                        freq_valid;
    logic [11:0]                 sym_out;
    logic                        sym_valid;
    logic                        sym_ready;
    logic                        sym_err;
    logic                        overflow;
    logic                        busy;

    int total = 0;
    int bad   = 0;
    int bw    = 1024;
    int f_arr [4096];

    lora_rx_chirp_demod dut (
        .clk(clk), .rst(rst), .start(start), .sf(sf), .chirpType(chirp_type),
        .BW_SR(bw_sr), .phaseInc_val(phase_inc), .freq_in(freq_in),
        .freq_valid(freq_valid), .sym_out(sym_out), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym_err(sym_err), .overflow(overflow), .busy(busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int sf_v, input logic up_v, input int inc);
        sf         = 4'(sf_v);
        chirp_type = up_v ? `TYPE_UPCHIRP : `TYPE_DOWNCHIRP;
        bw_sr      = 16'(bw);
        phase_inc  = 16'(inc);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic push(input int f);
        freq_in    = 16'(f);
        freq_valid = 1'b1;
        @(posedge clk); #1;
        freq_valid = 1'b0;
    endtask

    // Idle cycle with garbage on freq_in that must be ignored.
    task automatic gap();
        freq_in    = 16'($urandom_range(0, 65535));
        freq_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // gap_mode: 0 none, 1 a gap before every sample (50% duty), 2 random gaps.
    task automatic send_part(input int from, input int to, input int gap_mode);
        for (int k = from; k <= to; k++) begin
            if (gap_mode == 1) begin
                gap();
            end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                gap();
            end
            push(f_arr[k]);
        end
    endtask

    // Ideal chirp for symbol s: frequency starts s steps into the sweep and wraps at +-bw.
    task automatic gen_sym(input int s, input int n, input logic up);
        int step, v;
        step = (2 * bw) / n;
        for (int k = 0; k < n; k++) begin
            if (up) begin
                v = -bw + (s + k) * step;
                if (v >= bw) v = v - 2 * bw;
            end else begin
                v = bw - step - (s + k) * step;
                if (v < -bw) v = v + 2 * bw;
            end
            f_arr[k] = v;
        end
    endtask

    // Reference: list every in-symbol discontinuity, report N minus the first.
    function automatic int model_sym(input int n, input logic up, output int err);
        int wraps[$];
        int d;
        for (int k = 1; k < n; k++) begin
            d = f_arr[k] - f_arr[k-1];
            if (up ? (d < -bw) : (d > bw)) wraps.push_back(k);
        end
        err = (wraps.size() > 1) ? 1 : 0;
        if (wraps.size() == 0) return 0;
        return (n - wraps[0]) % n;
    endfunction

    int exp_sym, exp_err, sfv, n, s, j;
    logic up;

    initial begin
        rst = 1'b1; start = 1'b0; sf = 4'd7; chirp_type = `TYPE_UPCHIRP;
        bw_sr = 16'd1024; phase_inc = 16'd16; freq_in = 16'sd0;
        freq_valid = 1'b0; sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_out", sym_out, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_err", sym_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Samples in IDLE are ignored.
        gen_sym(37, 128, 1'b1);
        send_part(0, 127, 0);
        chk("idle_no_valid", sym_valid, 0);
        chk("idle_busy", busy, 0);

        // Symbol 0, with one-cycle latency check.
        do_start(7, 1'b1, 16);
        chk("start_busy", busy, 1);
        gen_sym(0, 128, 1'b1);
        send_part(0, 126, 0);
        chk("sym0_not_yet", sym_valid, 0);
        send_part(127, 127, 0);
        chk("sym0_valid", sym_valid, 1);
        chk("sym0_out", sym_out, 0);
        chk("sym0_err", sym_err, 0);

        // Back-to-back symbols 37 then 100.
        do_start(7, 1'b1, 16);
        gen_sym(37, 128, 1'b1);
        chk("sym37_first_value", f_arr[0], -432);
        send_part(0, 127, 0);
        chk("sym37_out", sym_out, 37);
        chk("sym37_model", sym_out, model_sym(128, 1'b1, exp_err));
        gen_sym(100, 128, 1'b1);
        send_part(0, 127, 0);
        chk("sym100_valid", sym_valid, 1);
        chk("sym100_out", sym_out, 100);
        chk("sym100_err", sym_err, 0);

        // Overflow: two results with no acceptance.
        do_start(7, 1'b1, 16);
        sym_ready = 1'b0;
        gen_sym(5, 128, 1'b1);
        send_part(0, 127, 0);
        chk("ovf_sym5_out", sym_out, 5);
        chk("ovf_sym5_flag", overflow, 0);
        gen_sym(9, 128, 1'b1);
        send_part(0, 127, 0);
        chk("ovf_sym9_out", sym_out, 9);
        chk("ovf_sym9_valid", sym_valid, 1);
        chk("ovf_flag", overflow, 1);
        repeat (3) gap();
        chk("ovf_held_valid", sym_valid, 1);
        sym_ready = 1'b1;
        @(posedge clk); #1;
        sym_ready = 1'b0;
        chk("ovf_accept_drop", sym_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Completion in the same cycle as acceptance is not an overflow.
        do_start(7, 1'b1, 16);
        chk("start_clears_ovf", overflow, 0);
        gen_sym(20, 128, 1'b1);
        send_part(0, 127, 0);
        chk("same_sym20_out", sym_out, 20);
        gen_sym(21, 128, 1'b1);
        send_part(0, 126, 0);
        sym_ready = 1'b1;
        send_part(127, 127, 0);
        chk("same_valid", sym_valid, 1);
        chk("same_out", sym_out, 21);
        chk("same_no_ovf", overflow, 0);
        gap();
        chk("same_then_drop", sym_valid, 0);

        // Two wraps in one symbol, then a 50% duty symbol 37.
        do_start(7, 1'b1, 16);
        for (int k = 0; k < 128; k++) f_arr[k] = 0;
        f_arr[19] = 900; f_arr[20] = -900;
        f_arr[59] = 900; f_arr[60] = -900;
        send_part(0, 127, 0);
        chk("err_out", sym_out, 108);
        chk("err_flag", sym_err, 1);
        chk("err_model", sym_out, model_sym(128, 1'b1, exp_err));
        chk("err_model_flag", sym_err, exp_err);
        gen_sym(37, 128, 1'b1);
        send_part(0, 126, 1);
        chk("duty_not_yet", sym_valid, 0);
        send_part(127, 127, 1);
        chk("duty_valid", sym_valid, 1);
        chk("duty_out", sym_out, 37);
        chk("duty_err", sym_err, 0);

        // sf below the minimum behaves as sf=6.
        do_start(4, 1'b1, 32);
        gen_sym(13, 64, 1'b1);
        send_part(0, 62, 0);
        chk("sf4_not_yet", sym_valid, 0);
        send_part(63, 63, 0);
        chk("sf4_valid", sym_valid, 1);
        chk("sf4_out", sym_out, 13);

        // Downchirp symbol 0.
        do_start(7, 1'b0, 16);
        gen_sym(0, 128, 1'b0);
        send_part(0, 127, 0);
        chk("down_valid", sym_valid, 1);
        chk("down_out", sym_out, 0);
        chk("down_err", sym_err, 0);

        // Randomized symbols against the reference model.
        for (int it = 0; it < 10; it++) begin
            sfv = $urandom_range(4, 10);
            n   = 1 << ((sfv < 6) ? 6 : sfv);
            up  = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, n - 1);
            gen_sym(s, n, up);
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(2, n - 2);
                f_arr[j-1] = up ? bw - 1 : -bw;
                f_arr[j]   = up ? -bw : bw - 1;
            end
            exp_sym = model_sym(n, up, exp_err);
            do_start(sfv, up, (2 * bw) / n);
            send_part(0, n - 1, 2);
            chk("rand_valid", sym_valid, 1);
            chk("rand_out", sym_out, exp_sym);
            chk("rand_err", sym_err, exp_err);
        end

        // Reset mid-symbol aborts and nothing is emitted afterwards.
        do_start(7, 1'b1, 16);
        gen_sym(37, 128, 1'b1);
        send_part(0, 69, 0);
        rst = 1'b1;
        #1;
        chk("midrst_sym_out", sym_out, 0);
        chk("midrst_valid", sym_valid, 0);
        chk("midrst_err", sym_err, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_part(70, 127, 0);
        send_part(0, 127, 0);
        chk("midrst_no_valid", sym_valid, 0);
        chk("midrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
